// File: rtl/mux_sel_serializer_pkg.sv
// Shared definitions for the mux_sel_serializer block.
// Holds the FSM state encoding, the word and select widths, and helpers that
// give the first and last bit index for either bit order.
package mux_sel_serializer_pkg;

  // Word width and the select width needed to address one bit of it.
  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  // IDLE waits for a word. SHIFT emits the data bits.
  // PARITY emits the optional check beat.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit index of the first beat of a frame.
  function automatic logic [IDX_W-1:0] first_idx(input bit msb_first);
    return msb_first ? IDX_W'(WORD_W - 1) : '0;
  endfunction

  // Bit index of the last data beat of a frame.
  function automatic logic [IDX_W-1:0] last_idx(input bit msb_first);
    return msb_first ? '0 : IDX_W'(WORD_W - 1);
  endfunction

endpackage

// File: rtl/mux_sel_serializer_sel_counter.sv
// Bit-select counter for the serializer.
// A load returns the counter to the first index of the frame. An enable moves
// it one step toward the last index, counting up or down as configured.
// Two flags flag the last index and the index just before it. The FSM uses
// them to decide, one cycle ahead, when the final beat starts.
module sel_counter #(
  parameter int             W     = 3,
  parameter logic [W-1:0]   FIRST = '0,
  parameter logic [W-1:0]   LAST  = '1,
  parameter bit             UP    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         terminal,
  output logic         penult
);

  // Index one step before LAST, in the direction of counting.
  localparam logic [W-1:0] PENULT = UP ? (LAST - W'(1)) : (LAST + W'(1));

  logic [W-1:0] count_reg;

  // Load takes priority over step. The count never wraps by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= FIRST;
    end else if (load) begin
      count_reg <= FIRST;
    end else if (en) begin
      count_reg <= UP ? (count_reg + W'(1)) : (count_reg - W'(1));
    end
  end

  assign count    = count_reg;
  assign terminal = (count_reg == LAST);
  assign penult   = (count_reg == PENULT);

endmodule

// File: rtl/mux_sel_serializer.sv
// Parallel-to-serial front end for the 8:1 bit-select mux stage.
//
// The block takes an 8-bit word on a valid/ready handshake and keeps it in
// hold_word. A select counter then steps through every bit position, and each
// bit goes out on a valid/ready serial port. The sel and hold_word outputs are
// also exported, so a downstream 8:1 mux can share them.
//
// If a new word arrives on the final-beat handshake, the block reloads
// immediately. This lets frames run back to back with no idle cycle between
// them.
//
// Build option: define SERIAL_PARITY_EN to append a ninth beat carrying even
// parity of the held word. During that beat sel stays at the final index.
module mux_sel_serializer
  import mux_sel_serializer_pkg::*;
#(
  parameter int DATA_W    = WORD_W,
  parameter int SEL_W     = IDX_W,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] hold_word,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last
);

  localparam bit              MSB   = (MSB_FIRST != 0);
  localparam logic [SEL_W-1:0] FIRST = first_idx(MSB);
  localparam logic [SEL_W-1:0] LAST  = last_idx(MSB);

  state_t            state_reg;
  logic [DATA_W-1:0] hold_word_reg;
  logic              ser_valid_reg;
  logic              ser_last_reg;

  logic [SEL_W-1:0]  sel_count;
  logic              sel_terminal;
  logic              sel_penult;

  logic              beat;
  logic              final_beat;
  logic              accept;
  logic              cnt_en;
  logic              data_bit;
  logic              parity_bit;

  // Handshake qualifiers.
  // in_ready depends on state and ser_ready only; it never looks at in_valid.
  assign beat       = ser_valid_reg & ser_ready;
  assign final_beat = beat & ser_last_reg;
  assign in_ready   = (state_reg == IDLE) | final_beat;
  assign accept     = in_valid & in_ready;

  // The select moves on data-beat handshakes only. It holds at the final index
  // until a reload, so it never free-runs while idle.
  assign cnt_en = beat & (state_reg == SHIFT) & ~sel_terminal;

  sel_counter #(
    .W     (SEL_W),
    .FIRST (FIRST),
    .LAST  (LAST),
    .UP    (!MSB)
  ) u_sel_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (cnt_en),
    .count    (sel_count),
    .terminal (sel_terminal),
    .penult   (sel_penult)
  );

  // Frame sequencing: capture the word, track the beats, flag the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_word_reg <= '0;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
    end else begin
      if (accept) begin
        hold_word_reg <= in_data;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg     <= SHIFT;
            ser_valid_reg <= 1'b1;
            ser_last_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          if (beat) begin
`ifdef SERIAL_PARITY_EN
            if (sel_terminal) begin
              state_reg    <= PARITY;
              ser_last_reg <= 1'b1;
            end else begin
              ser_last_reg <= 1'b0;
            end
`else
            if (sel_terminal) begin
              if (accept) begin
                state_reg     <= SHIFT;
                ser_valid_reg <= 1'b1;
              end else begin
                state_reg     <= IDLE;
                ser_valid_reg <= 1'b0;
              end
              ser_last_reg <= 1'b0;
            end else begin
              ser_last_reg <= sel_penult;
            end
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (beat) begin
            if (accept) begin
              state_reg     <= SHIFT;
              ser_valid_reg <= 1'b1;
            end else begin
              state_reg     <= IDLE;
              ser_valid_reg <= 1'b0;
            end
            ser_last_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg     <= IDLE;
          ser_valid_reg <= 1'b0;
          ser_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Serial bit: the held word indexed by the shared select, or parity on the
  // check beat. The output is forced low whenever no beat is being offered.
  assign data_bit   = hold_word_reg[sel_count];
  assign parity_bit = ^hold_word_reg;

`ifdef SERIAL_PARITY_EN
  assign ser_out = ser_valid_reg & ((state_reg == PARITY) ? parity_bit : data_bit);
`else
  assign ser_out = ser_valid_reg & data_bit;
`endif

  assign hold_word = hold_word_reg;
  assign sel       = sel_count;
  assign ser_valid = ser_valid_reg;
  assign ser_last  = ser_last_reg;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Bench for mux_sel_serializer.
// Two instances are checked side by side, one LSB-first and one MSB-first.
// A frame model built from queues of expected beats checks both instances on
// every cycle. Fixed tables and hand-written sequences cover the corner cases.
module tb_mux_sel_serializer;

`ifdef SERIAL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = PAR ? 9 : 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] hold_word [2];
  logic [2:0] sel       [2];
  logic       ser_out   [2];
  logic       ser_valid [2];
  logic       ser_ready [2];
  logic       ser_last  [2];

  always #5 clk = ~clk;

  mux_sel_serializer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .hold_word(hold_word[0]), .sel(sel[0]),
    .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]),
    .ser_last(ser_last[0]));

  mux_sel_serializer #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .hold_word(hold_word[1]), .sel(sel[1]),
    .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]),
    .ser_last(ser_last[1]));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of expected beats per instance.
  bit         m_bit  [2][64];
  int         m_sel  [2][64];
  bit         m_last [2][64];
  int         m_head [2];
  int         m_tail [2];
  logic [7:0] m_hold [2];
  int         m_idle_sel [2];

  function automatic int first_of(input int d);
    return (d == 1) ? 7 : 0;
  endfunction

  function automatic int last_of(input int d);
    return (d == 1) ? 0 : 7;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_head[d]     = 0;
      m_tail[d]     = 0;
      m_hold[d]     = 8'h00;
      m_idle_sel[d] = first_of(d);
    end
  endtask

  task automatic push_frame(input int d, input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (d == 1) ? 7 - k : k;
      m_bit[d][m_tail[d] % 64]  = w[idx];
      m_sel[d][m_tail[d] % 64]  = idx;
      m_last[d][m_tail[d] % 64] = (k == 7) && !PAR;
      m_tail[d]++;
    end
    if (PAR) begin
      m_bit[d][m_tail[d] % 64]  = ^w;
      m_sel[d][m_tail[d] % 64]  = last_of(d);
      m_last[d][m_tail[d] % 64] = 1'b1;
      m_tail[d]++;
    end
  endtask

  // Compare both instances against the model, then advance the model past the
  // coming clock edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int cnt;
      bit rdy_exp;
      cnt     = m_tail[d] - m_head[d];
      rdy_exp = (cnt == 0) || (cnt == 1 && ser_ready[d] === 1'b1);
      chk($sformatf("m%0d ser_valid", d), ser_valid[d], cnt > 0);
      chk($sformatf("m%0d in_ready", d), in_ready[d], rdy_exp);
      chk($sformatf("m%0d hold_word", d), hold_word[d], m_hold[d]);
      if (cnt > 0) begin
        chk($sformatf("m%0d ser_out", d), ser_out[d], m_bit[d][m_head[d] % 64]);
        chk($sformatf("m%0d sel", d), sel[d], m_sel[d][m_head[d] % 64]);
        chk($sformatf("m%0d ser_last", d), ser_last[d], m_last[d][m_head[d] % 64]);
      end else begin
        chk($sformatf("m%0d idle ser_out", d), ser_out[d], 0);
        chk($sformatf("m%0d idle sel", d), sel[d], m_idle_sel[d]);
        chk($sformatf("m%0d idle ser_last", d), ser_last[d], 0);
      end
      if (cnt > 0 && ser_ready[d] === 1'b1) begin
        if (cnt == 1) m_idle_sel[d] = m_sel[d][m_head[d] % 64];
        m_head[d]++;
      end
      if (in_valid[d] === 1'b1 && rdy_exp) begin
        push_frame(d, in_data[d]);
        m_hold[d] = in_data[d];
      end
    end
  endtask

  // Inputs are driven just after a rising edge, and checks run mid-cycle.
  task automatic tick();
    #3;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] w, input logic r);
    in_valid[d]  = v;
    in_data[d]   = w;
    ser_ready[d] = r;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       rdy;
    logic       e_valid;
    logic       e_out;
    logic [2:0] e_sel;
    logic       e_last;
    logic       e_inrdy;
  } vec_t;

  vec_t tbl [12];
  int   ntbl;

  initial begin
    logic [7:0] w;

    // Expected cycles for word 0xA5, LSB-first, with ser_ready held high.
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0};
`ifdef SERIAL_PARITY_EN
    tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1};
    ntbl = 11;
`else
    tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1};
    tbl[9] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1};
    ntbl = 10;
`endif

    for (int d = 0; d < 2; d++) set_in(d, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("reset ser_valid", ser_valid[0], 0);
    chk("reset in_ready", in_ready[0], 1);
    chk("reset sel lsb", sel[0], 0);
    chk("reset sel msb", sel[1], 7);
    chk("reset hold_word", hold_word[0], 8'h00);
    chk("reset ser_last", ser_last[0], 0);
    tick();

    // Single word 0xA5, LSB-first, table driven.
    for (int i = 0; i < ntbl; i++) begin
      set_in(0, tbl[i].valid, tbl[i].data, tbl[i].rdy);
      #2;
      chk($sformatf("tbl%0d ser_valid", i), ser_valid[0], tbl[i].e_valid);
      chk($sformatf("tbl%0d ser_out", i), ser_out[0], tbl[i].e_out);
      chk($sformatf("tbl%0d sel", i), sel[0], tbl[i].e_sel);
      chk($sformatf("tbl%0d ser_last", i), ser_last[0], tbl[i].e_last);
      chk($sformatf("tbl%0d in_ready", i), in_ready[0], tbl[i].e_inrdy);
      tick();
    end
    set_in(0, 1'b0, 8'h00, 1'b0);

    // MSB-first, word 0x81: bits emitted 7..0 with sel counting down.
    w = 8'h81;
    set_in(1, 1'b1, w, 1'b1);
    tick();
    in_valid[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("msb beat%0d ser_out", k), ser_out[1], w[7-k]);
      chk($sformatf("msb beat%0d sel", k), sel[1], 7 - k);
      chk($sformatf("msb beat%0d ser_last", k), ser_last[1], (k == 7) && !PAR);
      tick();
    end
`ifdef SERIAL_PARITY_EN
    tick();
`endif
    chk("msb end ser_valid", ser_valid[1], 0);
    set_in(1, 1'b0, 8'h00, 1'b0);

    // Back-to-back 0xFF then 0x00, with in_valid held: no bubble between frames.
    set_in(0, 1'b1, 8'hFF, 1'b1);
    tick();
    in_data[0] = 8'h00;
    for (int k = 0; k < 2 * FB; k++) begin
      chk($sformatf("b2b beat%0d ser_valid", k), ser_valid[0], 1);
      chk($sformatf("b2b beat%0d ser_out", k), ser_out[0], (k < 8) ? 1 : 0);
      if (k == FB - 1) chk("b2b reload in_ready", in_ready[0], 1);
      tick();
      if (k == FB - 1) in_valid[0] = 1'b0;
    end
    chk("b2b end ser_valid", ser_valid[0], 0);

    // Backpressure on bit 4 of 0x3C: sel and ser_out stay frozen.
    w = 8'h3C;
    set_in(0, 1'b1, w, 1'b1);
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    ser_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d sel", k), sel[0], 4);
      chk($sformatf("stall%0d ser_out", k), ser_out[0], w[4]);
      chk($sformatf("stall%0d ser_valid", k), ser_valid[0], 1);
      tick();
    end
    ser_ready[0] = 1'b1;
    for (int k = 4; k < 8; k++) begin
      chk($sformatf("resume bit%0d sel", k), sel[0], k);
      chk($sformatf("resume bit%0d ser_out", k), ser_out[0], w[k]);
      tick();
    end
`ifdef SERIAL_PARITY_EN
    tick();
`endif
    chk("stall end ser_valid", ser_valid[0], 0);

`ifdef SERIAL_PARITY_EN
    // Parity frame for 0x07: nine beats, and the ninth carries 1.
    w = 8'h07;
    set_in(0, 1'b1, w, 1'b1);
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("par beat%0d ser_last", k), ser_last[0], k == 8);
      chk($sformatf("par beat%0d ser_out", k), ser_out[0], (k == 8) ? 1 : w[k]);
      tick();
    end
    chk("par end ser_valid", ser_valid[0], 0);
`endif

    // Reset in the middle of a frame, at bit 3.
    set_in(0, 1'b1, 8'hF0, 1'b1);
    set_in(1, 1'b1, 8'hF0, 1'b1);
    tick();
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("prerst sel", sel[0], 3);
    rst = 1'b1;
    #1;
    chk("rst ser_valid", ser_valid[0], 0);
    chk("rst sel lsb", sel[0], 0);
    chk("rst sel msb", sel[1], 7);
    chk("rst in_ready", in_ready[0], 1);
    rst = 1'b0;
    model_reset();
    tick();
    chk("postrst ser_valid", ser_valid[0], 0);
    chk("postrst sel", sel[0], 0);
    chk("postrst in_ready", in_ready[0], 1);
    chk("postrst hold_word", hold_word[0], 8'h00);

    // Randomized traffic on both instances, checked by the frame model.
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        in_data[d]   = 8'($urandom);
        ser_ready[d] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) set_in(d, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 2 * FB; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
